// File: rtl/shift_normalizer_32_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_normalizer_32_if
// Description : Start/busy/done request and result bundle for the normalizer.
// Revision    : 1.0
// ============================================================================
interface shift_normalizer_32_if;
    logic        start;
    logic [31:0] datain;
    logic        signmode;
    logic        busy;
    logic        done;
    logic [31:0] dataout;
    logic [4:0]  shift5;
    logic        zero;

    modport master (
        output start, datain, signmode,
        input  busy, done, dataout, shift5, zero
    );

    modport slave (
        input  start, datain, signmode,
        output busy, done, dataout, shift5, zero
    );
endinterface
`default_nettype wire

// File: rtl/shift_normalizer_32.sv
`default_nettype none
// ============================================================================
// Module      : shift_normalizer_32
// Description : 5-step binary-search normalizer (leading-zero / redundant-sign count).
// Revision    : 1.0
// ============================================================================
module shift_normalizer_32 (
    input  wire                   clk,
    input  wire                   rst,
    shift_normalizer_32_if.slave  bus
);
    localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [2:0]  c_LAST_STEP = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w_q, w_d;
    logic        m_q, m_d;
    logic [4:0]  shift_q, shift_d;
    logic [2:0]  step_q, step_d;
    logic        zero_q, zero_d;

    logic [4:0]  w_k;
    logic [31:0] w_mask;
    logic        w_hit;

    // Step k = 16, 8, 4, 2, 1. Leading-zero mode tests the top k bits; sign mode
    // tests the top k+1 bits so the sign bit survives the shift.
    assign w_k    = 5'd16 >> step_q;
    assign w_mask = m_q ? (c_ALL_ONES << (6'd31 - {1'b0, w_k}))
                        : (c_ALL_ONES << (6'd32 - {1'b0, w_k}));
    assign w_hit  = ((w_q & w_mask) == 32'd0) ||
                    (m_q && ((w_q & w_mask) == w_mask));

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        m_d     = m_q;
        shift_d = shift_q;
        step_d  = step_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_d     = bus.datain;
                    m_d     = bus.signmode;
                    shift_d = 5'd0;
                    step_d  = 3'd0;
                    zero_d  = (bus.datain == 32'd0) ||
                              (bus.signmode && (bus.datain == c_ALL_ONES));
                    state_d = S_SEARCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEARCH: begin
                if (w_hit) begin
                    w_d     = w_q << w_k;
                    shift_d = shift_q + w_k;
                end
                if (step_q == c_LAST_STEP) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= 32'd0;
            m_q     <= 1'b0;
            shift_q <= 5'd0;
            step_q  <= 3'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            m_q     <= m_d;
            shift_q <= shift_d;
            step_q  <= step_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy    = (state_q == S_SEARCH);
    assign bus.done    = (state_q == S_DONE);
    assign bus.dataout = w_q;
    assign bus.shift5  = shift_q;
    assign bus.zero    = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_shift_normalizer_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_normalizer_32
// Description : Self-checking bench for shift_normalizer_32 against a count model.
// Revision    : 1.0
// ============================================================================
module tb_shift_normalizer_32;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    shift_normalizer_32_if bus ();

    shift_normalizer_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Normalization amount from the definitions: clz, or count of bits below
    // bit 31 that equal bit 31, both capped at 31.
    function automatic logic [4:0] ref_shift(input logic [31:0] d, input logic m);
        int n = 0;
        if (!m) begin
            while (n < 31 && !d[31-n]) n++;
        end else begin
            while (n < 31 && (d[30-n] == d[31])) n++;
        end
        return 5'(n);
    endfunction

    // Cycle-level model: cnt 0 = idle, 1..5 = searching, 6 = done cycle.
    int          cnt = 0;
    logic [31:0] op_d = '0;
    logic        op_m = 1'b0;
    logic [31:0] exp_do = '0;
    logic [4:0]  exp_sh = '0;
    logic        exp_z  = 1'b0;
    logic [4:0]  r_sh;
    logic [31:0] r_o;
    logic        r_z;

    assign r_sh = ref_shift(op_d, op_m);
    assign r_o  = op_d << r_sh;
    assign r_z  = (op_d == 32'd0) || (op_m && (op_d == 32'hFFFF_FFFF));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 0;
            exp_do <= '0;
            exp_sh <= '0;
            exp_z  <= 1'b0;
        end else if ((cnt == 0 || cnt == 6) && bus.start) begin
            cnt  <= 1;
            op_d <= bus.datain;
            op_m <= bus.signmode;
        end else if (cnt >= 1 && cnt <= 5) begin
            cnt <= cnt + 1;
            if (cnt == 5) begin
                exp_do <= r_o;
                exp_sh <= r_sh;
                exp_z  <= r_z;
            end
        end else begin
            cnt <= 0;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(cnt >= 1 && cnt <= 5));
        chk("done", 32'(bus.done), 32'(cnt == 6));
        if (cnt == 0 || cnt == 6) begin
            chk("dataout", bus.dataout, exp_do);
            chk("shift5", 32'(bus.shift5), 32'(exp_sh));
            chk("zero", 32'(bus.zero), 32'(exp_z));
        end
    end

    function automatic logic [31:0] gen(input logic m);
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            default: begin
                v = $urandom >> $urandom_range(0, 31);
                if (m && $urandom_range(0, 1) == 1) v = ~v;
            end
        endcase
        return v;
    endfunction

    task automatic run_op(input logic [31:0] d, input logic m, input logic rel_rst,
                          input logic [4:0] esh, input logic [31:0] edo, input logic ez);
        int lat   = 0;
        int nbusy = 0;
        bit seen  = 0;
        @(negedge clk);
        if (rel_rst) rst = 1'b0;
        bus.start = 1'b1; bus.datain = d; bus.signmode = m;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.datain = $urandom; bus.signmode = ~m;
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin seen = 1; lat = i; end
        end
        chk("latency", 32'(lat), 32'd6);
        chk("busy_cycles", 32'(nbusy), 32'd5);
        chk("lit_shift5", 32'(bus.shift5), 32'(esh));
        chk("lit_dataout", bus.dataout, edo);
        chk("lit_zero", 32'(bus.zero), 32'(ez));
    endtask

    initial begin
        int ndone;
        bit seen;
        bus.start = 1'b0; bus.datain = '0; bus.signmode = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dataout", bus.dataout, 32'd0);
        chk("rst_shift5", 32'(bus.shift5), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        @(negedge clk) rst = 1'b0;

        run_op(32'h0001_0000, 1'b0, 1'b0, 5'd15, 32'h8000_0000, 1'b0);
        run_op(32'h0000_0000, 1'b0, 1'b0, 5'd31, 32'h0000_0000, 1'b1);
        run_op(32'h8000_0000, 1'b0, 1'b0, 5'd0,  32'h8000_0000, 1'b0);
        run_op(32'hFFFF_8000, 1'b1, 1'b0, 5'd16, 32'h8000_0000, 1'b0);
        run_op(32'h4000_0000, 1'b1, 1'b0, 5'd0,  32'h4000_0000, 1'b0);
        run_op(32'hFFFF_FFFF, 1'b1, 1'b0, 5'd31, 32'h8000_0000, 1'b1);
        repeat (2) @(negedge clk);

        // start held high with a new operand every cycle
        ndone = 0;
        for (int i = 0; i <= 18; i++) begin
            @(negedge clk);
            if (i > 0 && bus.done) begin
                ndone++;
                if (i == 6)  chk("hs_shift_c6",  32'(bus.shift5), 32'd31);
                if (i == 12) chk("hs_shift_c12", 32'(bus.shift5), 32'd25);
                if (i == 18) chk("hs_shift_c18", 32'(bus.shift5), 32'd19);
            end
            bus.start = 1'b1; bus.signmode = 1'b0; bus.datain = 32'h1 << i;
        end
        chk("hs_done_pulses", 32'(ndone), 32'd3);
        @(posedge clk); #1 bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        chk("hs_last_seen", 32'(seen), 32'd1);
        chk("hs_last_shift", 32'(bus.shift5), 32'd13);
        repeat (2) @(negedge clk);

        // asynchronous reset in cycle 3 of a search
        @(negedge clk);
        bus.start = 1'b1; bus.datain = 32'h0000_0001; bus.signmode = 1'b0;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_dataout", bus.dataout, 32'd0);
        chk("arst_shift5", 32'(bus.shift5), 32'd0);
        chk("arst_zero", 32'(bus.zero), 32'd0);
        repeat (2) @(posedge clk);
        run_op(32'h0000_0100, 1'b0, 1'b1, 5'd23, 32'h8000_0000, 1'b0);
        repeat (2) @(negedge clk);

        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.signmode = m[0]; bus.datain = gen(m[0]);
            for (int i = 0; i < 6000; i++) begin
                @(negedge clk);
                bus.datain = gen(m[0]);
            end
            bus.start = 1'b0;
            repeat (8) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
